// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: access sizes, FSM states,
// writeback control payload and address helpers.
package mem_wb_stage_pkg;

  localparam int unsigned MEM_LAT_MAX = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] reg_dest;
    logic       reg_write;
    logic       mem_to_reg;
  } wb_ctrl_t;

  // True when the byte offset does not match the natural alignment of the size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  // Byte offset rounded down to the natural alignment of the size.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_dmem.sv
// Data memory: DEPTH x DATA_W words, per-byte write enables, combinational read.
// Contents are deliberately not reset.
module mem_wb_dmem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic [DATA_W/8-1:0]      we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane writes on the rising edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data-memory access with MEM_LAT-cycle latency,
// sub-word load/store handling and the MEM/WB pipeline register.
// Optional macro MEM_WB_MISALIGN_TRAP_EN: misaligned accesses trap (no write,
// no register write, one-cycle mem_exc) instead of being aligned down.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_read_data2,
  input  logic [4:0]        ex_reg_dest,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_load_unsigned,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [4:0]        wb_reg_dest,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              mem_exc
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             done_c;

  logic              is_mem_c, is_store_c, is_load_c, trap_c;
  logic [1:0]        off_c;
  logic [IDX_W-1:0]  idx_c;
  logic [NB-1:0]     be_c, we_c;
  logic [DATA_W-1:0] wdata_c, rdata_c, lane_c, ext_c, ld_data_c;

  wb_ctrl_t          wb_ctrl_q;

  // Instruction decode and address split; a read+write pair is a store.
  always_comb begin
    is_mem_c   = ex_mem_read | ex_mem_write;
    is_store_c = ex_mem_write;
    is_load_c  = ex_mem_read & ~ex_mem_write;
    off_c      = align_off(ex_size, ex_alu_result[1:0]);
    idx_c      = ex_alu_result[IDX_W+1:2];
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  assign trap_c = ex_valid & is_mem_c & misaligned(ex_size, ex_alu_result[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_c    = '1;
    wdata_c = ex_read_data2;
    case (ex_size)
      SZ_BYTE: begin
        be_c    = NB'(1) << off_c;
        wdata_c = {NB{ex_read_data2[7:0]}};
      end
      SZ_HALF: begin
        be_c    = NB'(3) << off_c;
        wdata_c = {(NB/2){ex_read_data2[15:0]}};
      end
      default: ;
    endcase
  end

  // Store commits only on the completion cycle, never during reset or a trap.
  assign we_c = (done_c && is_store_c && !trap_c && rst_n) ? be_c : '0;

  mem_wb_dmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (we_c),
    .addr  (idx_c),
    .wdata (wdata_c),
    .rdata (rdata_c)
  );

  // Load lane select and sign/zero extension.
  always_comb begin
    lane_c = rdata_c >> {off_c, 3'b000};
    case (ex_size)
      SZ_BYTE: ext_c = ex_load_unsigned ? DATA_W'(lane_c[7:0])
                                        : {{(DATA_W-8){lane_c[7]}}, lane_c[7:0]};
      SZ_HALF: ext_c = ex_load_unsigned ? DATA_W'(lane_c[15:0])
                                        : {{(DATA_W-16){lane_c[15]}}, lane_c[15:0]};
      default: ext_c = rdata_c;
    endcase
    ld_data_c = (is_load_c && !trap_c) ? ext_c : '0;
  end

  // Access FSM next state, stall and completion.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    mem_stall = 1'b0;
    done_c    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem_c || MEM_LAT == 1) begin
              done_c = 1'b1;
            end else begin
              mem_stall = 1'b1;
              state_n   = ST_BUSY;
              cnt_n     = CNT_W'(1);
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_LAST) begin
            done_c  = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            mem_stall = 1'b1;
            cnt_n     = cnt_q + CNT_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // MEM/WB register: loads on completion, otherwise inserts a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_ctrl_q     <= '0;
    end else if (done_c) begin
      wb_valid      <= 1'b1;
      wb_read_data  <= ld_data_c;
      wb_alu_result <= ex_alu_result;
      wb_ctrl_q     <= '{reg_dest:   ex_reg_dest,
                         reg_write:  ex_reg_write & ~trap_c,
                         mem_to_reg: ex_mem_to_reg};
    end else begin
      wb_valid            <= 1'b0;
      wb_ctrl_q.reg_write <= 1'b0;
    end
  end

  assign wb_reg_dest   = wb_ctrl_q.reg_dest;
  assign wb_reg_write  = wb_ctrl_q.reg_write;
  assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic exc_q;

  // Exception flag travels with the MEM/WB load and lasts one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= done_c & trap_c;
    end
  end

  assign mem_exc = exc_q;
`else
  assign mem_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage (MEM_LAT=3) against a byte-array
// reference model. Honours MEM_WB_MISALIGN_TRAP_EN if defined.
module tb_mem_wb_stage;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_read_data2;
  logic [4:0]    ex_reg_dest;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [1:0]    ex_size;
  logic          ex_load_unsigned;
  logic          ex_reg_write;
  logic          ex_mem_to_reg;
  logic          mem_stall;
  logic          wb_valid;
  logic [DW-1:0] wb_read_data;
  logic [DW-1:0] wb_alu_result;
  logic [4:0]    wb_reg_dest;
  logic          wb_reg_write;
  logic          wb_mem_to_reg;
  logic          mem_exc;

  mem_wb_stage #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .MEM_LAT (LAT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_alu_result    (ex_alu_result),
    .ex_read_data2    (ex_read_data2),
    .ex_reg_dest      (ex_reg_dest),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_size          (ex_size),
    .ex_load_unsigned (ex_load_unsigned),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .mem_stall        (mem_stall),
    .wb_valid         (wb_valid),
    .wb_read_data     (wb_read_data),
    .wb_alu_result    (wb_alu_result),
    .wb_reg_dest      (wb_reg_dest),
    .wb_reg_write     (wb_reg_write),
    .wb_mem_to_reg    (wb_mem_to_reg),
    .mem_exc          (mem_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Byte-addressed reference memory (little-endian lanes).
  logic [7:0] mdl [DEPTH*4];

`ifdef MEM_WB_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid         = 1'b0;
    ex_alu_result    = '0;
    ex_read_data2    = '0;
    ex_reg_dest      = '0;
    ex_mem_read      = 1'b0;
    ex_mem_write     = 1'b0;
    ex_size          = 2'b00;
    ex_load_unsigned = 1'b0;
    ex_reg_write     = 1'b0;
    ex_mem_to_reg    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_rdata"}, wb_read_data, 32'd0);
    chk({tag, "_alu"},   wb_alu_result, 32'd0);
    chk({tag, "_dest"},  32'(wb_reg_dest), 32'd0);
    chk({tag, "_rw"},    32'(wb_reg_write), 32'd0);
    chk({tag, "_m2r"},   32'(wb_mem_to_reg), 32'd0);
    chk({tag, "_exc"},   32'(mem_exc), 32'd0);
    chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
  endtask

  // One instruction through the stage; checks stall timing and the WB result.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] dst, input logic rw, input logic m2r,
                        output logic [31:0] rdata_obs);
    int nb, widx, off, base, nst;
    bit is_mem, mis, trap;
    logic [31:0] exp_rd;
    nb     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    is_mem = rd | wr;
    mis    = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
    trap   = TRAP && is_mem && mis;
    widx   = int'(addr >> 2) % DEPTH;
    off    = int'(addr[1:0]) & ~(nb - 1);
    base   = widx * 4 + off;
    exp_rd = '0;
    if (rd && !wr && !trap) begin
      for (int i = 0; i < nb; i++) exp_rd |= 32'(mdl[base + i]) << (8 * i);
      if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd |= 32'hFFFF_FFFF << (8 * nb);
    end
    nst = is_mem ? LAT - 1 : 0;

    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = addr; ex_read_data2 = data; ex_reg_dest = dst;
    ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_load_unsigned = uns;
    ex_reg_write = rw; ex_mem_to_reg = m2r;
    for (int k = 0; k <= nst; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("stall", 32'(mem_stall), 32'(k < nst));
      @(posedge clk);
      #1;
      if (k < nst) chk("stall_bubble", 32'(wb_valid), 32'd0);
    end
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_read_data", wb_read_data, exp_rd);
    chk("wb_alu_result", wb_alu_result, addr);
    chk("wb_reg_dest", 32'(wb_reg_dest), 32'(dst));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(rw && !trap));
    chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m2r));
    chk("mem_exc", 32'(mem_exc), 32'(trap));
    rdata_obs = wb_read_data;
    if (wr && !trap) begin
      for (int i = 0; i < nb; i++) mdl[base + i] = data[8*i +: 8];
    end
  endtask

  task automatic bubble();
    @(negedge clk);
    drive_idle();
    #1;
    chk("idle_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(wb_valid), 32'd0);
    chk("idle_rw", 32'(wb_reg_write), 32'd0);
    chk("idle_exc", 32'(mem_exc), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int kind;
    logic [31:0] a;
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known memory contents.
    for (int i = 0; i < DEPTH; i++) run_op(0, 1, 2'b10, 0, 32'(i * 4), $urandom, 5'd0, 0, 0, r);

    // Word store/load round trip and sub-word loads.
    run_op(0, 1, 2'b10, 0, 32'd8, 32'hDEADBEEF, 5'd1, 0, 0, r);
    run_op(1, 0, 2'b10, 0, 32'd8, 32'd0, 5'd2, 1, 1, r);
    chk("word_load_8", r, 32'hDEADBEEF);
    run_op(1, 0, 2'b00, 0, 32'd9, 32'd0, 5'd3, 1, 1, r);
    chk("lb_9", r, 32'hFFFFFFBE);
    run_op(1, 0, 2'b00, 1, 32'd9, 32'd0, 5'd4, 1, 1, r);
    chk("lbu_9", r, 32'h000000BE);

    // Half store into upper half of a zero word.
    run_op(0, 1, 2'b10, 0, 32'd12, 32'd0, 5'd0, 0, 0, r);
    run_op(0, 1, 2'b01, 0, 32'd14, 32'h0000_1234, 5'd0, 0, 0, r);
    run_op(1, 0, 2'b10, 0, 32'd12, 32'd0, 5'd5, 1, 1, r);
    chk("half_store_14", r, 32'h12340000);

    // Read+write together behaves as a store; size 11 acts as word.
    run_op(1, 1, 2'b11, 0, 32'd24, 32'hCAFEF00D, 5'd6, 1, 1, r);
    run_op(1, 0, 2'b11, 0, 32'd24, 32'd0, 5'd7, 1, 1, r);
    chk("both_store_24", r, 32'hCAFEF00D);

    // Reset in BUSY abandons a store.
    run_op(0, 1, 2'b10, 0, 32'd16, 32'h0BAD_0BAD, 5'd0, 0, 0, r);
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = 32'd16; ex_read_data2 = 32'hFFFFFFFF;
    ex_mem_write = 1'b1; ex_size = 2'b10; ex_reg_write = 1'b1; ex_reg_dest = 5'd9;
    #1;
    chk("busy_rst_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("busy_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    run_op(1, 0, 2'b10, 0, 32'd16, 32'd0, 5'd8, 1, 1, r);
    chk("busy_rst_mem", r, 32'h0BAD_0BAD);

    // Misaligned word store; trap or align-down depending on build.
    run_op(0, 1, 2'b10, 0, 32'd20, 32'h1111_2222, 5'd0, 0, 0, r);
    run_op(0, 1, 2'b10, 0, 32'd21, 32'h3333_4444, 5'd10, 1, 0, r);
    bubble();
    run_op(1, 0, 2'b10, 0, 32'd20, 32'd0, 5'd11, 1, 1, r);
    chk("misalign_word_20", r, TRAP ? 32'h1111_2222 : 32'h3333_4444);

    // Address wrap modulo DEPTH words.
    run_op(0, 1, 2'b10, 0, 32'(DEPTH * 4 + 4), 32'h5A5A_A5A5, 5'd0, 0, 0, r);
    run_op(1, 0, 2'b10, 0, 32'd4, 32'd0, 5'd12, 1, 1, r);
    chk("wrap_4", r, 32'h5A5A_A5A5);

    // Randomized mix against the model.
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'h0000_00FF;
      case (kind)
        0:       bubble();
        1, 2:    run_op(0, 0, 2'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), r);
        3, 4, 5: run_op(1, 0, 2'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), r);
        6:       run_op(0, 1, 2'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), r);
        default: run_op(1, 1, 2'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), r);
      endcase
    end
    bubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32: data and ALU width; multiple of 8.
- DEPTH, 64: data-memory depth in DATA_W words; power of two.
- MEM_LAT, 1: cycles per memory access; legal range 1..4.

REQ-002 Ports SHALL be:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX/MEM slot holds an instruction.
- ex_alu_result  in  DATA_W  address or ALU result.
- ex_read_data2  in  DATA_W  store data.
- ex_reg_dest  in  5  destination register.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
- ex_load_unsigned  in  1  zero-extend sub-word loads.
- ex_reg_write  in  1  passed to WB.
- ex_mem_to_reg  in  1  passed to WB.
- mem_stall  out  1  EX/MEM must hold its inputs.
- wb_valid  out  1  MEM/WB slot valid.
- wb_read_data  out  DATA_W  extended load data.
- wb_alu_result  out  DATA_W  registered ALU result.
- wb_reg_dest  out  5  registered destination register.
- wb_reg_write  out  1  registered register-write control.
- wb_mem_to_reg  out  1  registered memory-to-register control.
- mem_exc  out  1  misaligned access flag (see Configuration).

REQ-003 Clock SHALL be clk; reset SHALL be rst_n, synchronous, active-low.

Function
REQ-004 The MEM/WB register SHALL load on the completion cycle of each valid instruction; when ex_valid=0 it SHALL load wb_valid=0 and wb_reg_write=0.
REQ-005 Non-memory instructions (ex_valid=1, ex_mem_read=0, ex_mem_write=0) SHALL complete in 1 cycle with mem_stall=0.
REQ-006 Memory instructions SHALL use an FSM with two states, IDLE and BUSY, and a wait counter of width clog2(MEM_LAT)+1.
REQ-007 With MEM_LAT=1, the FSM SHALL stay in IDLE, mem_stall SHALL stay 0, and the access SHALL complete in the accepting cycle.
REQ-008 With MEM_LAT>1, in IDLE an accepted access SHALL drive mem_stall=1 combinationally, move to BUSY and set count=1.
REQ-009 In BUSY, mem_stall SHALL be 1 while count<MEM_LAT-1.
REQ-010 In BUSY, when count=MEM_LAT-1, mem_stall SHALL be 0, the access SHALL complete, and the FSM SHALL return to IDLE.
REQ-011 The upstream stage SHALL hold its inputs stable while mem_stall=1; the block SHALL NOT re-capture them.
REQ-012 A store SHALL write memory only on its completion cycle and only the bytes selected by the byte enables.
REQ-013 Byte enables SHALL be: byte, one lane selected by addr[1:0]; half, lanes {addr[1],0} and {addr[1],1}; word, all lanes.
REQ-014 Store data SHALL be replicated across lanes: byte x4, half x2.
REQ-015 A load SHALL read the word at index addr[clog2(DEPTH)+1:2], select the addressed byte or half, and sign-extend it, or zero-extend it when ex_load_unsigned=1.
REQ-016 Address bits above the index SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-017 ex_mem_read and ex_mem_write both 1 SHALL be treated as a store; wb_read_data SHALL be 0.
REQ-018 A load completing the cycle after a store to the same word SHALL return the post-store data.
REQ-019 A misaligned access is a half with addr[0]=1, or a word with addr[1:0]!=0.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE, count=0, all wb_* outputs to 0, mem_exc=0 and mem_stall=0.
REQ-021 rst_n=0 during BUSY SHALL abandon the access with no memory write.
REQ-022 Reset SHALL NOT clear memory contents.

Configuration
REQ-023 Macro MEM_WB_MISALIGN_TRAP_EN SHALL control misaligned accesses.
REQ-024 With MEM_WB_MISALIGN_TRAP_EN defined, a misaligned access SHALL suppress the write, set wb_reg_write=0, and pulse mem_exc=1 for one cycle, registered with the MEM/WB load.
REQ-025 Without MEM_WB_MISALIGN_TRAP_EN, misaligned addresses SHALL be aligned down by clearing the low bits, and mem_exc SHALL be tied 0.

Structure
REQ-026 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and MEM_LAT_MAX=4.
REQ-027 Storage SHALL be the sub-module mem_wb_dmem: a DEPTH x DATA_W array with per-byte write enables and combinational read.

Verification
REQ-028 Word store 0xDEADBEEF to addr 8, then word load from addr 8 -> wb_read_data=0xDEADBEEF on the second completion.
REQ-029 Signed byte load from addr 9 after REQ-028 -> 0xFFFFFFBE; unsigned byte load -> 0x000000BE.
REQ-030 Half store 0x1234 to addr 14 over word 0 -> word at addr 12 = 0x12340000.
REQ-031 MEM_LAT=3 load -> mem_stall=1 for 2 cycles, wb_valid=1 on the third edge.
REQ-032 Reset asserted in BUSY during a store of 0xFFFFFFFF to addr 16 -> memory word unchanged, all outputs 0.
REQ-033 With MEM_WB_MISALIGN_TRAP_EN, word store to addr 21 -> mem_exc pulses once, memory unchanged, wb_reg_write=0.
